// File: rtl/rom_port_arbiter.sv
// Shares one ROM read port among N_REQ requesters with round-robin arbitration and a tag pipeline
// that returns read data in grant order. Define ROM_ARB_PRIO0_EN to give requester 0 fixed top priority.
module rom_port_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 12,
    parameter int MEM_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic                    mem_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_rdata
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [1:0]        rst_sync;
    logic              arb_en;
    logic [ID_W-1:0]   last_gnt;
    logic [ID_W-1:0]   win_id;
    logic              win_any;
    logic              win_rr;
    logic              grant;
    logic [ADDR_W-1:0] win_addr;

    logic              tag_vld_p [0:MEM_LAT];
    logic [ID_W-1:0]   tag_id_p  [0:MEM_LAT];

    // Arbitration resumes only two clocks after reset release; assertion is immediate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign arb_en = rst_sync[1];

    always_comb begin
        logic [ID_W-1:0] cand;
        win_any  = 1'b0;
        win_rr   = 1'b0;
        win_id   = '0;
        cand     = '0;
        win_addr = '0;
`ifdef ROM_ARB_PRIO0_EN
        if (req[0]) begin
            win_any = 1'b1;
        end else begin
            // Pointer stays within 1..N_REQ-1, so requester 0 never disturbs the rotation.
            for (int i = 1; i < N_REQ; i++) begin
                cand = ID_W'(((int'(last_gnt) - 1 + i) % (N_REQ - 1)) + 1);
                if (!win_any && req[cand]) begin
                    win_any = 1'b1;
                    win_rr  = 1'b1;
                    win_id  = cand;
                end
            end
        end
`else
        for (int i = 1; i <= N_REQ; i++) begin
            cand = ID_W'((int'(last_gnt) + i) % N_REQ);
            if (!win_any && req[cand]) begin
                win_any = 1'b1;
                win_rr  = 1'b1;
                win_id  = cand;
            end
        end
`endif
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) win_addr = addr[i*ADDR_W +: ADDR_W];
        end
        grant = arb_en && win_any;
        gnt   = '0;
        if (grant) gnt[win_id] = 1'b1;
    end

    // Stage p0: ROM request register, issued on the edge that consumes the grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= ID_W'(N_REQ - 1);
            mem_en   <= 1'b0;
            mem_addr <= '0;
        end else begin
            mem_en <= grant;
            if (grant)          mem_addr <= win_addr;
            if (grant && win_rr) last_gnt <= win_id;
        end
    end

    // Stages p0..pMEM_LAT: tag shadows the ROM so the last stage lines up with mem_rdata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= MEM_LAT; k++) begin
                tag_vld_p[k] <= 1'b0;
                tag_id_p[k]  <= '0;
            end
        end else begin
            tag_vld_p[0] <= grant;
            tag_id_p[0]  <= win_id;
            for (int k = 1; k <= MEM_LAT; k++) begin
                tag_vld_p[k] <= tag_vld_p[k-1];
                tag_id_p[k]  <= tag_id_p[k-1];
            end
        end
    end

    // Output stage: register ROM data with its one-hot owner; rdata holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= '0;
            if (tag_vld_p[MEM_LAT]) begin
                rvalid[tag_id_p[MEM_LAT]] <= 1'b1;
                rdata                     <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: a behavioural arbiter model predicts grants and ROM
// requests; expected reads are queued and a separate monitor matches them against rvalid/rdata.
module tb_rom_port_arbiter;
    localparam int N_REQ   = 4;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 12;
    localparam int MEM_LAT = 2;
    localparam int ID_W    = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ*ADDR_W-1:0] addr = '0;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;
    logic                    mem_en;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_rdata;

    rom_port_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .gnt(gnt),
        .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int assertions = 0;
    int failures   = 0;
    int cycle      = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int                id;
        logic [DATA_W-1:0] data;
        int                due;
    } rd_t;
    rd_t sb[$];

    function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
        return a[11:0] ^ 12'h888 ^ {8'h00, a[15:12] ^ 4'h1};
    endfunction

    // ROM with MEM_LAT cycles from mem_en to data; garbage when not enabled
    logic [DATA_W-1:0] rom_pipe [1:MEM_LAT];
    always @(posedge clk) begin
        rom_pipe[1] <= mem_en ? rom_f(mem_addr) : DATA_W'($urandom);
        for (int k = 2; k <= MEM_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign mem_rdata = rom_pipe[MEM_LAT];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference model state
    int                ptr = N_REQ - 1;
    int                sync_cnt = 0;
    logic              exp_mem_en = 1'b0;
    logic [ADDR_W-1:0] exp_mem_addr = '0;

    function automatic int model_pick(input logic [N_REQ-1:0] r, input int p);
        int c;
`ifdef ROM_ARB_PRIO0_EN
        if (r[0]) return 0;
        for (int k = 1; k < N_REQ; k++) begin
            c = p + k;
            if (c > N_REQ - 1) c = c - (N_REQ - 1);
            if (r[c[ID_W-1:0]]) return c;
        end
`else
        for (int k = 1; k <= N_REQ; k++) begin
            c = (p + k) % N_REQ;
            if (r[c[ID_W-1:0]]) return c;
        end
`endif
        return -1;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input int i);
        return addr[i*ADDR_W +: ADDR_W];
    endfunction

    task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
        addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    // One clock: predict and check the grant, queue the read, then advance to just after the edge
    task automatic tick(output int w);
        logic [N_REQ-1:0] eg;
        @(negedge clk);
        w  = (rst_n && sync_cnt >= 2) ? model_pick(req, ptr) : -1;
        eg = '0;
        if (w >= 0) eg[w[ID_W-1:0]] = 1'b1;
        check("gnt", gnt, eg);
        check("mem_en", mem_en, exp_mem_en);
        check("mem_addr", mem_addr, exp_mem_addr);
        if (rst_n) begin
            if (w >= 0) begin
                exp_mem_en   = 1'b1;
                exp_mem_addr = addr_of(w);
                sb.push_back('{w, rom_f(addr_of(w)), cycle + MEM_LAT + 2});
`ifdef ROM_ARB_PRIO0_EN
                if (w != 0) ptr = w;
`else
                ptr = w;
`endif
            end else begin
                exp_mem_en = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        if (rst_n && sync_cnt < 2) sync_cnt++;
    endtask

    task automatic assert_reset();
        rst_n        = 1'b0;
        sb.delete();
        ptr          = N_REQ - 1;
        sync_cnt     = 0;
        exp_mem_en   = 1'b0;
        exp_mem_addr = '0;
    endtask

    // Monitor: pops the scoreboard when a read is due and compares the returned data
    logic [DATA_W-1:0] last_rdata = '0;
    rd_t               e;
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rvalid_in_reset", rvalid, '0);
            check("rdata_in_reset", rdata, '0);
            last_rdata = '0;
        end else if (sb.size() > 0 && sb[0].due <= cycle) begin
            e = sb.pop_front();
            check("rvalid", rvalid, 64'(1) << e.id);
            check("rdata", rdata, e.data);
            if (rvalid != '0) last_rdata = rdata;
        end else begin
            check("rvalid_idle", rvalid, '0);
            check("rdata_hold", rdata, last_rdata);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        #2;
        assert_reset();
        req = '1;
        for (int i = 0; i < N_REQ; i++) set_addr(i, ADDR_W'($urandom));
        repeat (3) tick(w);
        rst_n = 1'b1;

        // All four requesting continuously: rotation and back-to-back grants
        for (int n = 0; n < 10; n++) begin
            tick(w);
            if (w >= 0) set_addr(w, ADDR_W'($urandom));
        end
        req = '0;
        repeat (6) tick(w);

        // Single read with known address
        req = 4'b0100;
        set_addr(2, 16'h1234);
        tick(w);
        req = '0;
        repeat (6) tick(w);

        // Back-to-back reads from one requester
        req = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            set_addr(1, ADDR_W'(16'h0010 + k));
            tick(w);
        end
        req = '0;
        repeat (6) tick(w);

        // Idle gap after a grant to 2, then wrap-around 3 -> 0
        req = 4'b0100;
        set_addr(2, ADDR_W'($urandom));
        tick(w);
        req = '0;
        repeat (5) tick(w);
        req = 4'b1001;
        set_addr(0, ADDR_W'($urandom));
        set_addr(3, ADDR_W'($urandom));
        for (int n = 0; n < 2; n++) begin
            tick(w);
            if (w >= 0) req[w[ID_W-1:0]] = 1'b0;
        end
        req = '0;
        repeat (6) tick(w);

        // Requester 0 held with all others pending, then dropped
        req = '1;
        for (int n = 0; n < 4; n++) begin
            tick(w);
            if (w >= 0) set_addr(w, ADDR_W'($urandom));
        end
        req[0] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick(w);
            if (w >= 0) set_addr(w, ADDR_W'($urandom));
        end
        req = '0;
        repeat (6) tick(w);

        // Random traffic; a pending request is never withdrawn before its grant
        for (int n = 0; n < 300; n++) begin
            tick(w);
            if (w >= 0) begin
                req[w[ID_W-1:0]] = 1'($urandom_range(1, 0));
                set_addr(w, ADDR_W'($urandom));
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i] && ($urandom_range(2, 0) == 0)) begin
                    req[i] = 1'b1;
                    set_addr(i, ADDR_W'($urandom));
                end
            end
        end

        // Reset pulse with reads in flight: they must never return
        req = '1;
        repeat (3) begin
            tick(w);
            if (w >= 0) set_addr(w, ADDR_W'($urandom));
        end
        assert_reset();
        tick(w);
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick(w);
            if (w >= 0) set_addr(w, ADDR_W'($urandom));
        end

        req = '0;
        repeat (10) tick(w);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
